lsu_mem_port: RTL and testbench

- Data-memory side of the load/store path: consumes the `lw_en`/`sw_en` strobes from the instruction decoder together with address, store data and funct3.
- Drives a req/gnt/rvalid memory port and returns aligned, sign/zero-extended load data.
- Holds the core stalled until the access completes.
- Sits between the decoder/ALU and data_mem.

---
 rtl/lsu_mem_port_pkg.sv | 27 ++
 rtl/lsu_mem_port_if.sv | 23 ++
 rtl/lsu_mem_port_align.sv | 48 ++++
 rtl/lsu_mem_port.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the LSU memory port: funct3 size codes, FSM states
// and the alignment predicate used by the optional misalignment trap.
package lsu_mem_port_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Unsupported funct3 codes behave as word accesses.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            LSU_B, LSU_BU: return 1'b0;
            LSU_H, LSU_HU: return lo[0];
            default:       return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// req/gnt/rvalid data-memory bus between the LSU (master) and data_mem (slave).
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-lane extraction with sign/zero extension.
module lsu_mem_port_align
    import lsu_mem_port_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (funct3_i)
            LSU_B, LSU_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (funct3_i == LSU_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'b0, byte_sel};
            end
            LSU_H, LSU_HU: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = (funct3_i == LSU_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'b0, half_sel};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory port: turns decoder lw/sw strobes into one req/gnt/rvalid
// access, stalls the core meanwhile. Build option: LSU_MISALIGN_TRAP_EN.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lw_en,
    input  logic              sw_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              bus_err,
    lsu_mem_port_if.master    mem
);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              start;
    logic              misaligned;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_ext;

    assign start = lw_en | sw_en;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = lsu_misaligned(funct3, addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_mem_port_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem.mem_rdata),
        .be_o      (be),
        .wdata_o   (wdata_rep),
        .rdata_o   (load_ext)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        stall         = 1'b0;
        done          = 1'b0;
        bus_err       = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'h0;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = LSU_REQ;
                        cnt_d   = 8'd0;
                    end
                end
            end
            LSU_REQ: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.mem_be    = be;
                mem.mem_wdata = wdata_rep;
                cnt_d         = cnt_q + 8'd1;
                // A response beats the timeout; the timeout beats a late grant.
                if (mem.mem_gnt && mem.mem_rvalid) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : load_ext;
                end else if (cnt_d == TIMEOUT_LIM) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else if (mem.mem_gnt) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (mem.mem_rvalid) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : load_ext;
                end else if (cnt_d == TIMEOUT_LIM) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            LSU_DONE: begin
                done    = 1'b1;
                bus_err = err_q;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LSU_IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            we_q     <= 1'b0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == LSU_IDLE && start) begin
                addr_q   <= addr;
                funct3_q <= funct3;
                wdata_q  <= wdata;
                we_q     <= sw_en & ~lw_en;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a result scoreboard (TIMEOUT_CYC=8).
module tb_lsu_mem_port;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lw_en, sw_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, bus_err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] addr;
        int          stalls;
        int          reqc;
    } exp_t;

    exp_t sb_q[$];

    lsu_mem_port_if #(.ADDR_W(32)) bus ();

    lsu_mem_port #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lw_en   (lw_en),
        .sw_en   (sw_en),
        .funct3  (funct3),
        .addr    (addr),
        .wdata   (wdata),
        .stall   (stall),
        .done    (done),
        .rdata   (rdata),
        .bus_err (bus_err),
        .mem     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One access; caller is at a negedge. resp: 0 none, 1 rvalid after gnt, 2 rvalid with gnt.
    task automatic go(input logic lw, input logic sw, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int gnt_wait, input int resp, input logic [31:0] rword,
                      input logic [31:0] e_rdata, input logic e_err, input logic chk_rd,
                      input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
                      input int e_stalls, input int e_reqc);
        exp_t e, g;
        int   stalls = 0;
        int   reqc = 0;
        bit   granted = 0;
        bit   resp_done = 0;
        bit   fin = 0;
        e.rdata = e_rdata; e.err = e_err; e.chk_rdata = chk_rd; e.be = e_be; e.we = e_we;
        e.wdata = e_wdata; e.addr = {a[31:2], 2'b00}; e.stalls = e_stalls; e.reqc = e_reqc;
        sb_q.push_back(e);
        lw_en = lw; sw_en = sw; funct3 = f3; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !fin; c++) begin
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
            if (c > 0) begin lw_en = 1'b0; sw_en = 1'b0; end
            if (bus.mem_req) begin
                chk("req_addr", bus.mem_addr, e.addr);
                chk("req_be", {28'h0, bus.mem_be}, {28'h0, e.be});
                chk("req_we", {31'h0, bus.mem_we}, {31'h0, e.we});
                chk("req_wdata", bus.mem_wdata, e.wdata);
                if (reqc == gnt_wait) begin
                    bus.mem_gnt = 1'b1; granted = 1;
                    if (resp == 2) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rword; end
                end
                reqc++;
            end else if (granted && resp == 1 && !resp_done) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rword; resp_done = 1;
            end
            #1;
            if (done) begin
                fin = 1;
                g = sb_q.pop_front();
                if (g.chk_rdata) chk("rdata", rdata, g.rdata);
                chk("bus_err", {31'h0, bus_err}, {31'h0, g.err});
                chk("stall_at_done", {31'h0, stall}, 32'h0);
                chk("stall_cycles", 32'(stalls), 32'(g.stalls));
                chk("req_cycles", 32'(reqc), 32'(g.reqc));
                $display("txn %0d: f3=%b addr=%h we=%b rdata=%h bus_err=%b stalls=%0d", txn, f3, a,
                         g.we, rdata, bus_err, stalls);
            end else begin
                chk("stall_busy", {31'h0, stall}, 32'h1);
                if (stall) stalls++;
            end
            @(negedge clk);
        end
        if (!fin) begin
            chk("done_seen", 32'h0, 32'h1);
            void'(sb_q.pop_front());
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk("done_pulse", {31'h0, done}, 32'h0);
        chk("err_pulse", {31'h0, bus_err}, 32'h0);
        if (chk_rd) chk("rdata_hold", rdata, e_rdata);
        @(negedge clk);
        txn++;
    endtask

    initial begin
        rst_n = 1'b0; lw_en = 1'b0; sw_en = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //  lw sw f3      addr          wdata         gw rs rword         e_rdata       er ck be       we e_wdata        st rq
        go(1, 0, 3'b010, 32'h0000_0100, 32'h0,        0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 4'b1111, 0, 32'h0,         3, 1);
        go(1, 0, 3'b000, 32'h0000_0103, 32'h0,        0, 1, 32'h80FF_FF7F, 32'hFFFF_FF80, 0, 1, 4'b1000, 0, 32'h0,         3, 1);
        go(1, 0, 3'b100, 32'h0000_0103, 32'h0,        0, 1, 32'h80FF_FF7F, 32'h0000_0080, 0, 1, 4'b1000, 0, 32'h0,         3, 1);
        go(0, 1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 0, 1, 32'h0,        32'h0,         0, 0, 4'b1100, 1, 32'hABCD_ABCD, 3, 1);
        go(1, 0, 3'b010, 32'h0000_0110, 32'h0,        4, 1, 32'h1122_3344, 32'h1122_3344, 0, 1, 4'b1111, 0, 32'h0,         7, 5);
        go(1, 0, 3'b010, 32'h0000_0200, 32'h0,        0, 0, 32'h0,        32'h0,         1, 1, 4'b1111, 0, 32'h0,         9, 1);
        go(1, 0, 3'b001, 32'h0000_0102, 32'h0,        0, 1, 32'h8001_7FFF, 32'hFFFF_8001, 0, 1, 4'b1100, 0, 32'h0,         3, 1);
        go(1, 0, 3'b101, 32'h0000_0100, 32'h0,        0, 1, 32'h8001_F00D, 32'h0000_F00D, 0, 1, 4'b0011, 0, 32'h0,         3, 1);
        go(0, 1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 1, 32'h0,        32'h0,         0, 0, 4'b0010, 1, 32'hA5A5_A5A5, 3, 1);
        go(0, 1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 1, 32'h0,        32'h0,         0, 0, 4'b1111, 1, 32'hCAFE_F00D, 3, 1);
        go(1, 1, 3'b010, 32'h0000_0108, 32'h5555_5555, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1, 4'b1111, 0, 32'h5555_5555, 3, 1);
        go(1, 0, 3'b011, 32'h0000_010C, 32'h0,        0, 1, 32'h7654_3210, 32'h7654_3210, 0, 1, 4'b1111, 0, 32'h0,         3, 1);
        go(1, 0, 3'b010, 32'h0000_0120, 32'h0,        0, 2, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 0, 1, 4'b1111, 0, 32'h0,         2, 1);
        go(1, 0, 3'b010, 32'h0000_0124, 32'h0,       20, 1, 32'h0,        32'h0,         1, 1, 4'b1111, 0, 32'h0,         9, 8);
`ifdef LSU_MISALIGN_TRAP_EN
        go(1, 0, 3'b010, 32'h0000_0101, 32'h0,        0, 1, 32'h1357_9BDF, 32'h0,         1, 1, 4'b1111, 0, 32'h0,         1, 0);
        go(1, 0, 3'b001, 32'h0000_0103, 32'h0,        0, 1, 32'hFEDC_0123, 32'h0,         1, 1, 4'b1100, 0, 32'h0,         1, 0);
`else
        go(1, 0, 3'b010, 32'h0000_0101, 32'h0,        0, 1, 32'h1357_9BDF, 32'h1357_9BDF, 0, 1, 4'b1111, 0, 32'h0,         3, 1);
        go(1, 0, 3'b001, 32'h0000_0103, 32'h0,        0, 1, 32'hFEDC_0123, 32'hFFFF_FEDC, 0, 1, 4'b1100, 0, 32'h0,         3, 1);
`endif

        // Stray handshakes while idle must not start anything.
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stray_done", {31'h0, done}, 32'h0);
            chk("stray_req", {31'h0, bus.mem_req}, 32'h0);
            chk("stray_stall", {31'h0, stall}, 32'h0);
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(negedge clk);
        $display("txn %0d: stray gnt/rvalid in IDLE", txn++);

        // Reset while waiting for rvalid, then a late rvalid.
        lw_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
        @(negedge clk);
        lw_en = 1'b0;
        #1;
        chk("mid_req", {31'h0, bus.mem_req}, 32'h1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        chk("mid_wait_stall", {31'h0, stall}, 32'h1);
        chk("mid_wait_req", {31'h0, bus.mem_req}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstmid_stall", {31'h0, stall}, 32'h0);
            chk("rstmid_done", {31'h0, done}, 32'h0);
            chk("rstmid_err", {31'h0, bus_err}, 32'h0);
            chk("rstmid_req", {31'h0, bus.mem_req}, 32'h0);
            chk("rstmid_rdata", rdata, 32'h0);
            chk("rstmid_addr", bus.mem_addr, 32'h0);
            chk("rstmid_be", {28'h0, bus.mem_be}, 32'h0);
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
        end
        $display("txn %0d: reset during WAIT, late rvalid ignored", txn++);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
